// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter merging ALU (A) and load (B)
// writebacks onto one register-file write port, plus pending-write scoreboard.
// Ports:
//   clk, reset (async, active-high)
//   a_valid/a_addr/a_data -> a_ready : ALU writeback request
//   b_valid/b_addr/b_data -> b_ready : load writeback request
//   issue_valid/issue_addr : mark destination pending
//   flush                  : clear all pending state
//   ra1/ra2 -> busy1/busy2 : pending lookups
//   rf_we/rf_wa/rf_wd      : registered register-file write port
//   pend_cnt               : number of pending registers
//   last_grant             : 0 = A won last transfer, 1 = B
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              busy1,
   output logic              busy2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic [ADDR_W:0]   pend_cnt,
   output logic              last_grant
);

   localparam int NREG = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pend_nxt;
   logic              xfer;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic              set_en;
   logic              inc;
   logic              dec;

   // Under contention the requester not named by last_grant wins.
   assign a_ready = a_valid && (!b_valid || last_grant);
   assign b_ready = b_valid && (!a_valid || !last_grant);
   assign xfer    = a_ready || b_ready;
   assign g_addr  = a_ready ? a_addr : b_addr;
   assign g_data  = a_ready ? a_data : b_data;

   assign busy1 = (ra1 != '0) && pending[ra1];
   assign busy2 = (ra2 != '0) && pending[ra2];

   assign set_en = issue_valid && (issue_addr != '0);

   // rf_wa is never zero while rf_we is high, so bit 0 is never touched.
   // A set on the same address as the clear wins (new producer).
   assign inc = set_en && !pending[issue_addr];
   assign dec = rf_we && pending[rf_wa] &&
                !(set_en && (issue_addr == rf_wa));

   always_comb begin
      pend_nxt = pending;
      if (rf_we)
         pend_nxt[rf_wa] = 1'b0;
      if (set_en)
         pend_nxt[issue_addr] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we      <= 1'b0;
         rf_wa      <= '0;
         rf_wd      <= '0;
         last_grant <= 1'b1;
      end else begin
         rf_we <= xfer && (g_addr != '0);
         if (xfer) begin
            last_grant <= b_ready;
            // Address-0 transfers are swallowed; keep the port contents.
            if (g_addr != '0) begin
               rf_wa <= g_addr;
               rf_wd <= g_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else if (flush) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending <= pend_nxt;
         if (inc && !dec)
            pend_cnt <= pend_cnt + CNT_ONE;
         else if (dec && !inc)
            pend_cnt <= pend_cnt - CNT_ONE;
      end
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 DATA_W, 32, write-data width.
REQ-002 ADDR_W, 5, register address width (32 registers, x0 hard-wired zero).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_valid/a_addr/a_data  input  1/ADDR_W/DATA_W  requester A (ALU writeback) request.
REQ-006 a_ready  output  1  A accepted this cycle.
REQ-007 b_valid/b_addr/b_data  input  1/ADDR_W/DATA_W  requester B (load writeback) request.
REQ-008 b_ready  output  1  B accepted this cycle.
REQ-009 issue_valid/issue_addr  input  1/ADDR_W  mark a destination register as pending.
REQ-010 flush  input  1  synchronous clear of all pending state.
REQ-011 ra1/ra2  input  ADDR_W  read addresses to check.
REQ-012 busy1/busy2  output  1  ra1/ra2 has a pending write.
REQ-013 rf_we/rf_wa/rf_wd  output  1/ADDR_W/DATA_W  registered drive of the register-file write port.
REQ-014 pend_cnt  output  ADDR_W+1  number of pending registers.
REQ-015 last_grant  output  1  0 = A won most recent transfer, 1 = B.

Function
REQ-016 Transfer on a requester = valid && ready in the same cycle; requester holds valid/addr/data stable until transfer.
REQ-017 a_ready and b_ready are combinational from valids and last_grant; never both high in one cycle.
REQ-018 Only A valid -> a_ready=1; only B valid -> b_ready=1; neither -> both 0.
REQ-019 Both valid -> grant the requester not named by last_grant (round-robin); last_grant updates only on a transfer.
REQ-020 Transfer at edge N -> rf_we=1, rf_wa/rf_wd = granted addr/data during cycle N+1 (one-cycle latency).
REQ-021 No transfer at edge N -> rf_we=0 in cycle N+1; rf_wa/rf_wd hold their previous values.
REQ-022 Transfer with addr 0 is accepted (ready=1) but produces rf_we=0.
REQ-023 Back-to-back transfers every cycle are supported; sustained throughput one write per cycle.
REQ-024 Pending vector, one bit per register; bit 0 never set.
REQ-025 issue_valid with issue_addr!=0 sets pending[issue_addr] at the edge.
REQ-026 A cycle with rf_we=1 clears pending[rf_wa] at the end of that cycle, so busy drops the cycle after the register file is written.
REQ-027 Set and clear of the same address in the same cycle -> bit remains set (new producer wins).
REQ-028 Issue to an already-pending address leaves bit set and pend_cnt unchanged.
REQ-029 busyN = pending[raN] combinationally; busyN=0 when raN=0.
REQ-030 pend_cnt tracks set bits exactly: +1 on new set, -1 on clear of a set bit, net 0 when both occur on different addresses; never wraps (max 31).
REQ-031 Clear of a non-pending bit does not change pend_cnt.
REQ-032 flush clears all pending bits and pend_cnt at the edge, overriding same-cycle issue; does not affect arbitration or rf_* pipeline.

Reset
REQ-033 reset asserted -> immediately rf_we=0, rf_wa=0, rf_wd=0, pending=0, pend_cnt=0, last_grant=1 (A wins first contention).
REQ-034 Reset mid-transfer discards the in-flight write: no rf_we pulse after reset release.
REQ-035 a_ready/b_ready follow valids per REQ-018/019 from the first cycle after reset release.

Verification
REQ-036 After reset, A and B both valid, addrs 3/4, data 0x11/0x22 for 2 cycles -> A then B accepted; rf_we=1 with (3,0x11) then (4,0x22); last_grant 0 then 1.
REQ-037 Only B valid for 3 cycles, addrs 5,6,7 -> b_ready=1 each cycle; a_ready=0; three consecutive rf_we pulses in order.
REQ-038 Issue addr 9, ra1=9 -> busy1=1, pend_cnt=1; A writes addr 9 -> busy1 stays 1 during rf_we cycle, 0 the next; pend_cnt=0.
REQ-039 rf_we to addr 9 coincident with issue_valid addr 9 -> busy stays 1, pend_cnt unchanged; issue addr 0 -> no change; A write to addr 0 -> a_ready=1, rf_we=0.
REQ-040 Issue addrs 1..31 -> pend_cnt=31; flush with concurrent issue addr 2 -> pend_cnt=0, all busy=0.
REQ-041 Assert reset the cycle after a transfer -> rf_we=0 at once; no write appears after release; pending and pend_cnt zero.
